// File: rtl/reset_seq_pkg.sv
// Package: reset_seq_pkg
// Shared state encoding and default parameter values for the reset sequencer.
// No ports; imported by reset_sequencer and its testbench.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_WAIT    = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

  localparam int unsigned DEF_NUM_OUT         = 3;
  localparam int unsigned DEF_SYNC_STAGES     = 2;
  localparam int unsigned DEF_HOLD_CYCLES     = 16;
  localparam int unsigned DEF_STAGGER_CYCLES  = 4;
  localparam int unsigned DEF_TIMEOUT_CYCLES  = 1024;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 8;
  localparam logic [2:0]  DEF_SW_MASK         = 3'b100;

endpackage

// File: rtl/reset_sequencer_sync.sv
// Synchroniser primitives used by reset_sequencer.
//   reset_sync : async-assert / sync-deassert reset chain.
//     clock in, rst_n in (async active-low), rst_sync_n out (released STAGES edges after rst_n rises)
//   sync_ff    : plain multi-flop synchroniser for a WIDTH-bit bus, cleared by rst_n.
//     clock in, rst_n in, d in [WIDTH], q out [WIDTH]
module reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic rst_n,
  output logic rst_sync_n
);

  logic [STAGES-1:0] chain_r;
  logic [STAGES:0]   shifted_s;

  // A one is shifted in behind the released reset; the last stage is the clean release.
  assign shifted_s  = {chain_r, 1'b1};
  assign rst_sync_n = chain_r[STAGES-1];

  // Reset chain: cleared asynchronously, filled with ones synchronously.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      chain_r <= '0;
    end else begin
      chain_r <= shifted_s[STAGES-1:0];
    end
  end

endmodule

module sync_ff #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] chain_r [STAGES];

  assign q = chain_r[STAGES-1];

  // Metastability chain for asynchronous level inputs.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        chain_r[i] <= '0;
      end
    end else begin
      chain_r[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        chain_r[i] <= chain_r[i-1];
      end
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Module: reset_sequencer
// Synchronises the board reset and releases NUM_OUT reset domains one at a time,
// lowest index first, each gated on its ready handshake (with timeout). A debounced
// push-button soft reset re-sequences only the SW_MASK domains.
// Ports:
//   clock          in   system clock
//   i_reset        in   async active-low board reset (clears every flop)
//   i_sw_reset     in   async active-high soft-reset button
//   i_dep_ready    in   [NUM_OUT] per-domain init-done
//   o_reset        out  [NUM_OUT] active-high domain resets
//   o_all_released out  high in ST_RUN with every domain released
//   o_fault        out  [NUM_OUT] sticky ready-timeout flags
//   o_state        out  [3] current FSM state
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned        NUM_OUT         = DEF_NUM_OUT,
  parameter int unsigned        SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int unsigned        HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned        STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int unsigned        TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES,
  parameter int unsigned        DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter logic [NUM_OUT-1:0] SW_MASK         = DEF_SW_MASK
) (
  input  logic               clock,
  input  logic               i_reset,
  input  logic               i_sw_reset,
  input  logic [NUM_OUT-1:0] i_dep_ready,
  output logic [NUM_OUT-1:0] o_reset,
  output logic               o_all_released,
  output logic [NUM_OUT-1:0] o_fault,
  output logic [2:0]         o_state
);

  // One shared counter serves hold, stagger and timeout, so size it for the largest.
  localparam int unsigned CNT_LIM0 = (HOLD_CYCLES > STAGGER_CYCLES) ? HOLD_CYCLES : STAGGER_CYCLES;
  localparam int unsigned CNT_LIM  = (CNT_LIM0 > TIMEOUT_CYCLES) ? CNT_LIM0 : TIMEOUT_CYCLES;
  localparam int unsigned CNT_W    = $clog2(CNT_LIM) + 1;
  localparam int unsigned DEB_W    = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int unsigned IDX_W    = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [DEB_W-1:0] DEB_LIM   = DEB_W'(DEBOUNCE_CYCLES);
  localparam logic [DEB_W-1:0] DEB_LAST  = DEB_W'(DEBOUNCE_CYCLES - 1);

  // Index of the lowest set bit; the release order is ascending index.
  function automatic logic [IDX_W-1:0] lowest_set(input logic [NUM_OUT-1:0] m);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int i = int'(NUM_OUT) - 1; i >= 0; i--) begin
      if (m[i]) begin
        r = IDX_W'(i);
      end else begin
        r = r;
      end
    end
    return r;
  endfunction

  logic               rst_int_n_s;
  logic [NUM_OUT-1:0] dep_ready_s;
  logic               sw_s;
  logic               sw_req_s;
  logic               ready_hit_s;
  logic               tout_hit_s;

  state_e             state_r,   state_nx;
  logic [CNT_W-1:0]   cnt_r,     cnt_nx;
  logic [NUM_OUT-1:0] mask_r,    mask_nx;
  logic [IDX_W-1:0]   idx_r,     idx_nx;
  logic [NUM_OUT-1:0] reset_r,   reset_nx;
  logic [NUM_OUT-1:0] fault_r,   fault_nx;
  logic               all_rel_r, all_rel_nx;
  logic [DEB_W-1:0]   deb_r,     deb_nx;

  reset_sync #(.STAGES(SYNC_STAGES)) u_rst_sync (
    .clock      (clock),
    .rst_n      (i_reset),
    .rst_sync_n (rst_int_n_s)
  );

  sync_ff #(.WIDTH(NUM_OUT), .STAGES(SYNC_STAGES)) u_ready_sync (
    .clock (clock),
    .rst_n (i_reset),
    .d     (i_dep_ready),
    .q     (dep_ready_s)
  );

  sync_ff #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_sw_sync (
    .clock (clock),
    .rst_n (i_reset),
    .d     (i_sw_reset),
    .q     (sw_s)
  );

  // The request fires on the edge that takes the debounce counter to its limit.
  assign sw_req_s    = sw_s && (deb_r == DEB_LAST);
  assign ready_hit_s = (cnt_r >= STAG_LAST) && dep_ready_s[idx_r];
  assign tout_hit_s  = (cnt_r == TOUT_LAST);

  // Debounce counter: saturates while the button is held, clears when released.
  always_comb begin
    deb_nx = deb_r;
    if (!sw_s) begin
      deb_nx = '0;
    end else if (deb_r != DEB_LIM) begin
      deb_nx = deb_r + DEB_W'(1);
    end else begin
      deb_nx = deb_r;
    end
  end

  // Sequencing FSM next-state and datapath.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    mask_nx  = mask_r;
    idx_nx   = idx_r;
    reset_nx = reset_r;
    fault_nx = fault_r;
    case (state_r)
      ST_ASSERT: begin
        if (rst_int_n_s) begin
          mask_nx  = '1;
          cnt_nx   = '0;
          state_nx = ST_HOLD;
        end else begin
          state_nx = ST_ASSERT;
        end
      end
      ST_HOLD: begin
        if (cnt_r == HOLD_LAST) begin
          idx_nx   = lowest_set(mask_r);
          state_nx = ST_RELEASE;
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      ST_RELEASE: begin
        // Clearing the mask bit here lets ST_WAIT pick the next domain directly.
        reset_nx[idx_r] = 1'b0;
        mask_nx[idx_r]  = 1'b0;
        cnt_nx          = '0;
        state_nx        = ST_WAIT;
      end
      ST_WAIT: begin
        if (ready_hit_s || tout_hit_s) begin
          if (!ready_hit_s) begin
            fault_nx[idx_r] = 1'b1;
          end else begin
            fault_nx = fault_r;
          end
          cnt_nx = '0;
          if (|mask_r) begin
            idx_nx   = lowest_set(mask_r);
            state_nx = ST_RELEASE;
          end else begin
            state_nx = ST_RUN;
          end
        end else begin
          cnt_nx = cnt_r + CNT_W'(1);
        end
      end
      ST_RUN: begin
        if (sw_req_s && (SW_MASK != '0)) begin
          reset_nx = reset_r | SW_MASK;
          mask_nx  = SW_MASK;
          cnt_nx   = '0;
          state_nx = ST_HOLD;
        end else begin
          state_nx = ST_RUN;
        end
      end
      default: begin
        state_nx = ST_ASSERT;
      end
    endcase
    all_rel_nx = (state_nx == ST_RUN) && !(|reset_nx);
  end

  // State and output registers; the board reset clears everything immediately.
  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state_r   <= ST_ASSERT;
      cnt_r     <= '0;
      mask_r    <= '1;
      idx_r     <= '0;
      reset_r   <= '1;
      fault_r   <= '0;
      all_rel_r <= 1'b0;
      deb_r     <= '0;
    end else begin
      state_r   <= state_nx;
      cnt_r     <= cnt_nx;
      mask_r    <= mask_nx;
      idx_r     <= idx_nx;
      reset_r   <= reset_nx;
      fault_r   <= fault_nx;
      all_rel_r <= all_rel_nx;
      deb_r     <= deb_nx;
    end
  end

  assign o_reset        = reset_r;
  assign o_fault        = fault_r;
  assign o_all_released = all_rel_r;
  assign o_state        = state_r;

endmodule

// File: tb/tb_reset_sequencer.sv
// Testbench for reset_sequencer (default parameters). Output changes are matched
// against a queue of expected {cycle, o_reset, o_all_released, o_fault} events.
module tb_reset_sequencer;
  import reset_seq_pkg::*;

  logic       clock = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_sw_reset = 1'b0;
  logic [2:0] i_dep_ready = 3'b000;
  logic [2:0] o_reset;
  logic       o_all_released;
  logic [2:0] o_fault;
  logic [2:0] o_state;

  reset_sequencer dut (
    .clock          (clock),
    .i_reset        (i_reset),
    .i_sw_reset     (i_sw_reset),
    .i_dep_ready    (i_dep_ready),
    .o_reset        (o_reset),
    .o_all_released (o_all_released),
    .o_fault        (o_fault),
    .o_state        (o_state)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_fail = 0;

  localparam logic [15:0] NEVER = 16'hFFFF;

  // d: cycle after release at which i_dep_ready[k] rises; fall/run/fault_cyc: expected cycles
  typedef struct packed {
    logic [2:0][15:0] d;
    logic [2:0][15:0] fall;
    logic [15:0]      run;
    logic [15:0]      fault_cyc;
    logic [2:0]       fault_val;
  } vec_t;

  typedef struct packed {
    int         cyc;
    logic [2:0] rst;
    logic       all;
    logic [2:0] flt;
  } ev_t;

  ev_t  sb_q[$];
  logic mon_en = 1'b0;
  logic [6:0] prev;
  vec_t vecs [5];

  function automatic vec_t mk_vec(input logic [15:0] d0, d1, d2, f0, f1, f2, run, fc,
                                  input logic [2:0] fv);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
    v.fall[0] = f0; v.fall[1] = f1; v.fall[2] = f2;
    v.run = run; v.fault_cyc = fc; v.fault_val = fv;
    return v;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  task automatic push_ev(input int c, input logic [2:0] r, input logic a, input logic [2:0] f);
    ev_t e;
    e.cyc = c; e.rst = r; e.all = a; e.flt = f;
    sb_q.push_back(e);
  endtask

  // Output monitor: every change of the observed outputs must match the next queued event.
  always @(negedge clock) begin
    logic [6:0] cur;
    ev_t        e;
    cur = {o_reset, o_all_released, o_fault};
    if (mon_en && (cur !== prev)) begin
      n_cmp++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change: got rst=%b all=%b flt=%b at cycle %0d, required no change",
                 o_reset, o_all_released, o_fault, cyc);
      end else begin
        e = sb_q.pop_front();
        if (e.cyc != cyc || cur !== {e.rst, e.all, e.flt}) begin
          n_fail++;
          $display("FAIL event: got cyc=%0d rst=%b all=%b flt=%b, expected cyc=%0d rst=%b all=%b flt=%b",
                   cyc, o_reset, o_all_released, o_fault, e.cyc, e.rst, e.all, e.flt);
        end
      end
      prev = cur;
    end
  end

  // Pull the board reset low between edges and check the clear took effect without a clock.
  task automatic async_reset_now();
    mon_en = 1'b0;
    i_reset = 1'b0;
    i_dep_ready = 3'b000;
    i_sw_reset = 1'b0;
    #2;
    check("async_o_reset", int'(o_reset), 7);
    check("async_o_fault", int'(o_fault), 0);
    check("async_all_rel", int'(o_all_released), 0);
    check("async_state", int'(o_state), int'(ST_ASSERT));
    sb_q.delete();
  endtask

  // Full power-up sequence for one table entry; optional abort and button press.
  task automatic run_vec(input vec_t v, input int abort_at, input int sw_at);
    int         r0;
    logic [2:0] r;
    logic [2:0] f;
    logic       fpend;
    @(posedge clock); #1;
    async_reset_now();
    repeat (3) @(posedge clock);
    @(posedge clock); #1;
    r0 = cyc;
    i_reset = 1'b1;
    for (int k = 0; k < 3; k++) if (v.d[k] == 16'd0) i_dep_ready[k] = 1'b1;
    r = 3'b111; f = 3'b000; fpend = (v.fault_cyc != 16'd0);
    for (int k = 0; k < 3; k++) begin
      if (fpend && (v.fault_cyc < v.fall[k])) begin
        f = v.fault_val;
        push_ev(r0 + int'(v.fault_cyc), r, 1'b0, f);
        fpend = 1'b0;
      end
      r[k] = 1'b0;
      push_ev(r0 + int'(v.fall[k]), r, 1'b0, f);
    end
    push_ev(r0 + int'(v.run), r, 1'b1, f);
    prev = {o_reset, o_all_released, o_fault};
    mon_en = 1'b1;
    for (int c = 1; c <= int'(v.run) + 10; c++) begin
      @(posedge clock); #1;
      if (abort_at > 0 && c == abort_at) begin
        check("abort_state_wait", int'(o_state), int'(ST_WAIT));
        async_reset_now();
        return;
      end
      for (int k = 0; k < 3; k++) if (int'(v.d[k]) == c) i_dep_ready[k] = 1'b1;
      if (sw_at > 0 && c == sw_at) i_sw_reset = 1'b1;
      if (sw_at > 0 && c == sw_at + 20) i_sw_reset = 1'b0;
    end
    check("events_left", sb_q.size(), 0);
    check("final_state", int'(o_state), int'(ST_RUN));
    check("final_fault", int'(o_fault), int'(v.fault_val));
    check("final_all_rel", int'(o_all_released), 1);
  endtask

  task automatic press(input int n);
    i_sw_reset = 1'b1;
    repeat (n) @(posedge clock);
    #1;
    i_sw_reset = 1'b0;
  endtask

  initial begin
    int p;
    vecs[0] = mk_vec(16'd0,   16'd0, 16'd0,  16'd20, 16'd25,  16'd30,   16'd34,   16'd0,    3'b000);
    vecs[1] = mk_vec(16'd100, 16'd0, 16'd0,  16'd20, 16'd104, 16'd109,  16'd113,  16'd0,    3'b000);
    vecs[2] = mk_vec(16'd0,   NEVER, 16'd0,  16'd20, 16'd25,  16'd1050, 16'd1054, 16'd1049, 3'b010);
    vecs[3] = mk_vec(16'd0,   16'd0, 16'd50, 16'd20, 16'd25,  16'd30,   16'd53,   16'd0,    3'b000);
    vecs[4] = mk_vec(16'd22,  16'd0, 16'd0,  16'd20, 16'd26,  16'd31,   16'd35,   16'd0,    3'b000);

    repeat (3) @(posedge clock);
    #1;
    check("por_o_reset", int'(o_reset), 7);
    check("por_o_fault", int'(o_fault), 0);
    check("por_all_rel", int'(o_all_released), 0);
    check("por_state", int'(o_state), int'(ST_ASSERT));

    for (int i = 0; i < 5; i++) run_vec(vecs[i], 0, 0);

    // Board reset while waiting on domain 1, then the full sequence again.
    run_vec(vecs[0], 27, 0);
    run_vec(vecs[0], 0, 0);

    // Short press is filtered out.
    @(posedge clock); #1;
    press(7);
    repeat (40) @(posedge clock);
    #1;
    check("short_press_state", int'(o_state), int'(ST_RUN));
    check("short_press_reset", int'(o_reset), 0);

    // Long press: exactly one re-sequence of domain 2.
    @(posedge clock); #1;
    p = cyc;
    push_ev(p + 10, 3'b100, 1'b0, 3'b000);
    push_ev(p + 27, 3'b000, 1'b0, 3'b000);
    push_ev(p + 31, 3'b000, 1'b1, 3'b000);
    press(20);
    repeat (60) @(posedge clock);
    #1;
    check("soft_events_left", sb_q.size(), 0);
    check("soft_state", int'(o_state), int'(ST_RUN));
    check("soft_all_rel", int'(o_all_released), 1);

    // Button press landing in ST_HOLD is dropped.
    run_vec(vecs[0], 0, 1);
    repeat (30) @(posedge clock);
    #1;
    check("hold_press_state", int'(o_state), int'(ST_RUN));
    check("hold_press_reset", int'(o_reset), 0);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
